// File: rtl/present_core.sv
// present_core: iterative PRESENT-64 block cipher, one round per clock, 80/128-bit key.
// Ports:
//   sys_clk, sys_rst_n        clock (rising edge), asynchronous active-low reset
//   start, decrypt            request and mode, sampled together in IDLE
//   data_in [63:0]            plaintext or ciphertext, sampled with start
//   key_in [KEY_W-1:0]        user key, sampled with start
//   busy, done                busy while computing; done pulses one cycle as data_out updates
//   data_out [63:0]           result register, held until the next done
// Build option: define PRESENT_DEC_EN to include the decryption path.
module present_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             decrypt,
  input  logic [63:0]      data_in,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic [63:0]      data_out
);
  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_core: ROUNDS must be 1..31");
  end
  // nibble n of SBOX holds S(n)
  localparam logic [63:0] SBOX   = 64'h2174_8FE3_DA09_B65C;
  localparam int          CNT_LO = (KEY_W == 128) ? 62 : 15;
  localparam logic [4:0]  LAST   = 5'(ROUNDS);
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, FINAL} state_e;
  state_e           state_q, state_d;
  logic [63:0]      st_q, st_d, dout_q, dout_d;
  logic [KEY_W-1:0] key_q, key_d, fkey, dkey;
  logic [4:0]       cnt_q, cnt_d;
  logic             dec_q, dec_d, dec_go;
  logic [63:0]      est, dst;

  function automatic logic [3:0] sb(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb(x[4*i +: 4]);
    return r;
  endfunction

  // bit i moves to 16*i mod 63; bit 63 stays
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] r;
    r[63] = x[63];
    for (int i = 0; i < 63; i++) r[(i * 16) % 63] = x[i];
    return r;
  endfunction

  function automatic logic [KEY_W-1:0] fwd_upd(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] r;
    r = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    r[KEY_W-1 -: 4] = sb(r[KEY_W-1 -: 4]);
    if (KEY_W == 128) r[KEY_W-5 -: 4] = sb(r[KEY_W-5 -: 4]);
    r[CNT_LO +: 5] = r[CNT_LO +: 5] ^ c;
    return r;
  endfunction

`ifdef PRESENT_DEC_EN
  localparam logic [63:0] ISBOX = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] isb(input logic [3:0] x);
    return ISBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] is_layer(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = isb(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] ip_layer(input logic [63:0] x);
    logic [63:0] r;
    r[63] = x[63];
    for (int i = 0; i < 63; i++) r[i] = x[(i * 16) % 63];
    return r;
  endfunction

  // undo fwd_upd step by step in reverse order, ending with a right rotate by 61
  function automatic logic [KEY_W-1:0] inv_upd(input logic [KEY_W-1:0] k, input logic [4:0] c);
    logic [KEY_W-1:0] r;
    r = k;
    r[CNT_LO +: 5] = r[CNT_LO +: 5] ^ c;
    if (KEY_W == 128) r[KEY_W-5 -: 4] = isb(r[KEY_W-5 -: 4]);
    r[KEY_W-1 -: 4] = isb(r[KEY_W-1 -: 4]);
    return {r[60:0], r[KEY_W-1:61]};
  endfunction

  assign dec_go = decrypt;
  assign dkey   = inv_upd(key_q, cnt_q);
  assign dst    = is_layer(ip_layer(st_q)) ^ dkey[KEY_W-1 -: 64];
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
  // dec_q never rises, so these placeholders are never selected
  assign dec_go = 1'b0;
  assign dkey   = key_q;
  assign dst    = st_q;
`endif

  assign fkey = fwd_upd(key_q, cnt_q);
  assign est  = p_layer(s_layer(st_q ^ key_q[KEY_W-1 -: 64]));

  // the result is registered on the last round's edge so done and data_out change together
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: if (start) begin
        st_d    = data_in;
        key_d   = key_in;
        cnt_d   = 5'd1;
        dec_d   = dec_go;
        state_d = dec_go ? KEYEXP : ROUND;
      end
`ifdef PRESENT_DEC_EN
      // run the schedule forward to K_{ROUNDS+1}, then strip the final whitening key
      KEYEXP: begin
        key_d = fkey;
        cnt_d = (cnt_q == LAST) ? LAST : cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          st_d    = st_q ^ fkey[KEY_W-1 -: 64];
          state_d = ROUND;
        end
      end
`endif
      ROUND: if (dec_q) begin
        key_d = dkey;
        st_d  = dst;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          dout_d  = dst;
          state_d = FINAL;
        end
      end else begin
        key_d = fkey;
        st_d  = est;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          dout_d  = est ^ fkey[KEY_W-1 -: 64];
          state_d = FINAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      dout_q  <= dout_d;
    end
  end

  assign busy     = state_q inside {KEYEXP, ROUND};
  assign done     = state_q == FINAL;
  assign data_out = dout_q;
endmodule
